// File: rtl/muldiv_unit_if.sv
// Port bundle of the RV32M multiply/divide sequencer: execute-side request,
// writeback-side result, and the `mul`/`div` IP core connections.
interface muldiv_unit_if;
  // Handshakes: a request transfers on a rising edge where in_valid && in_ready
  // (in_ready depends only on state); a result is offered with out_valid and
  // held, with out_result/out_tag stable, until a rising edge sees out_ready.
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_ce;
  logic [63:0] mul_p;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_valid;
  logic        div_aclken;
  logic [63:0] div_dout;
  logic        div_dout_valid;
  logic [2:0]  dbg_state;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, kill, out_ready,
    input  mul_p, div_dout, div_dout_valid,
    output in_ready, out_valid, out_result, out_tag,
    output mul_a, mul_b, mul_ce,
    output div_dividend, div_divisor, div_valid, div_aclken,
    output dbg_state
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, kill, out_ready,
    output mul_p, div_dout, div_dout_valid,
    input  in_ready, out_valid, out_result, out_tag,
    input  mul_a, mul_b, mul_ce,
    input  div_dividend, div_divisor, div_valid, div_aclken,
    input  dbg_state
  );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide sequencer in front of unsigned `mul`/`div` IP cores.
// Optional feature macro: MULDIV_DIV0_BYPASS_EN (divide special cases skip the divider).
module muldiv_unit #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 36
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [2:0] {
    RST_DRAIN = 3'd0,
    IDLE      = 3'd1,
    MUL_WAIT  = 3'd2,
    DIV_WAIT  = 3'd3,
    DRAIN     = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;

  logic [2:0]  op_q;
  logic [4:0]  tag_q;
  logic        sign_a_q;
  logic        sign_b_q;
  logic [31:0] a_raw_q;
  logic        div_zero_q;
  logic        div_ovf_q;
  logic [31:0] result_q;
  logic        out_valid_q;
  logic [31:0] mul_a_q;
  logic [31:0] mul_b_q;
  logic [31:0] dividend_q;
  logic [31:0] divisor_q;
  logic        div_valid_q;

  // Incoming operation decode
  logic        accept;
  logic        is_div_in;
  logic        signed_a_in;
  logic        signed_b_in;
  logic        neg_a_in;
  logic        neg_b_in;
  logic [31:0] mag_a_in;
  logic [31:0] mag_b_in;
  logic        b_zero_in;
  logic        ovf_in;

  // Result shaping
  logic [63:0] prod_fix;
  logic [31:0] mul_res;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] div_res;

  function automatic logic [31:0] special_result(input logic is_rem, input logic b_zero,
                                                 input logic [31:0] a);
    if (is_rem) return b_zero ? a : 32'd0;
    else        return b_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
  endfunction

  assign accept      = (state == IDLE) && bus.in_valid && !bus.kill;
  assign is_div_in   = bus.in_op[2];
  assign signed_a_in = (bus.in_op == OP_MUL) || (bus.in_op == OP_MULH) ||
                       (bus.in_op == OP_MULHSU) || (bus.in_op == OP_DIV) ||
                       (bus.in_op == OP_REM);
  assign signed_b_in = (bus.in_op == OP_MUL) || (bus.in_op == OP_MULH) ||
                       (bus.in_op == OP_DIV) || (bus.in_op == OP_REM);
  assign neg_a_in    = signed_a_in && bus.in_a[31];
  assign neg_b_in    = signed_b_in && bus.in_b[31];
  assign mag_a_in    = neg_a_in ? (32'd0 - bus.in_a) : bus.in_a;
  assign mag_b_in    = neg_b_in ? (32'd0 - bus.in_b) : bus.in_b;
  assign b_zero_in   = (bus.in_b == 32'd0);
  assign ovf_in      = ((bus.in_op == OP_DIV) || (bus.in_op == OP_REM)) &&
                       (bus.in_a == 32'h8000_0000) && (bus.in_b == 32'hFFFF_FFFF);

`ifdef MULDIV_DIV0_BYPASS_EN
  logic special_in;
  assign special_in = is_div_in && (b_zero_in || ovf_in);
`endif

  // Sign flags are only ever set for signed operands, so they double as the
  // "signed op" qualifier for correction.
  assign prod_fix = (sign_a_q ^ sign_b_q) ? (64'd0 - bus.mul_p) : bus.mul_p;
  assign mul_res  = (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
  assign quo_fix  = (sign_a_q ^ sign_b_q) ? (32'd0 - bus.div_dout[63:32]) : bus.div_dout[63:32];
  assign rem_fix  = sign_a_q ? (32'd0 - bus.div_dout[31:0]) : bus.div_dout[31:0];
  assign div_res  = (div_zero_q || div_ovf_q) ? special_result(op_q[1], div_zero_q, a_raw_q)
                                              : (op_q[1] ? rem_fix : quo_fix);

  always_comb begin
    state_next = state;
    case (state)
      RST_DRAIN: if (cnt <= CNT_W'(1)) state_next = IDLE;
      IDLE: begin
        if (accept) begin
          if (!is_div_in) state_next = MUL_WAIT;
`ifdef MULDIV_DIV0_BYPASS_EN
          else if (special_in) state_next = DONE;
`endif
          else state_next = DIV_WAIT;
        end
      end
      MUL_WAIT: begin
        if (bus.kill)              state_next = IDLE;
        else if (cnt == '0)        state_next = DONE;
      end
      // A kill racing the divider strobe needs no drain: the result is already here.
      DIV_WAIT: begin
        if (bus.kill)              state_next = bus.div_dout_valid ? IDLE : DRAIN;
        else if (bus.div_dout_valid) state_next = DONE;
      end
      DRAIN:     if (bus.div_dout_valid) state_next = IDLE;
      DONE:      if (bus.kill || bus.out_ready) state_next = IDLE;
      default:   state_next = RST_DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RST_DRAIN;
      cnt         <= CNT_W'(DIV_LAT);
      op_q        <= '0;
      tag_q       <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      a_raw_q     <= '0;
      div_zero_q  <= 1'b0;
      div_ovf_q   <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      div_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      out_valid_q <= (state_next == DONE);
      div_valid_q <= 1'b0;
      case (state)
        RST_DRAIN: if (cnt != '0) cnt <= cnt - CNT_W'(1);
        IDLE: begin
          if (accept) begin
            op_q       <= bus.in_op;
            tag_q      <= bus.in_tag;
            sign_a_q   <= neg_a_in;
            sign_b_q   <= neg_b_in;
            a_raw_q    <= bus.in_a;
            div_zero_q <= is_div_in && b_zero_in;
            div_ovf_q  <= ovf_in;
            if (!is_div_in) begin
              mul_a_q <= mag_a_in;
              mul_b_q <= mag_b_in;
              cnt     <= CNT_W'(MUL_LAT);
            end else begin
              dividend_q <= mag_a_in;
              divisor_q  <= mag_b_in;
`ifdef MULDIV_DIV0_BYPASS_EN
              if (special_in) result_q <= special_result(bus.in_op[1], b_zero_in, bus.in_a);
              else            div_valid_q <= 1'b1;
`else
              div_valid_q <= 1'b1;
`endif
            end
          end
        end
        MUL_WAIT: begin
          if (!bus.kill) begin
            if (cnt == '0) result_q <= mul_res;
            else           cnt <= cnt - CNT_W'(1);
          end
        end
        DIV_WAIT: if (!bus.kill && bus.div_dout_valid) result_q <= div_res;
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = result_q;
  assign bus.out_tag      = tag_q;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
  assign bus.mul_ce       = (state == MUL_WAIT);
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
  assign bus.div_valid    = div_valid_q;
  assign bus.div_aclken   = 1'b1;
  assign bus.dbg_state    = state;

endmodule
